// File: rtl/elevator_pkg.sv
// Shared codes for the elevator car controller. The floor and direction codes
// are the contract with binary_to_segment; keep them defined only here.
package elevator_pkg;

    // Floor digit codes
    localparam logic [3:0] FLOOR_1 = 4'd1;
    localparam logic [3:0] FLOOR_2 = 4'd2;
    localparam logic [3:0] FLOOR_3 = 4'd3;

    // Direction digit codes
    localparam logic [3:0] DIR_UP   = 4'd4;
    localparam logic [3:0] DIR_DOWN = 4'd8;
    localparam logic [3:0] DIR_IDLE = 4'd12;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MOVE_UP   = 2'd1;
    localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
    localparam logic [1:0] ST_DOOR      = 2'd3;

    // One-hot call mask of a floor number (1..3); out-of-range gives no bit.
    function automatic logic [2:0] floor_onehot(input logic [1:0] floor);
        logic [2:0] mask;
        mask = 3'b000;
        case (floor)
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b010;
            2'd3:    mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    // True when a call exists strictly above (up=1) or below (up=0) a floor.
    function automatic logic calls_dir(input logic [1:0] floor, input logic [2:0] pend,
                                       input logic up);
        logic hit;
        hit = 1'b0;
        case (floor)
            2'd1:    hit = up ? (pend[1] | pend[2]) : 1'b0;
            2'd2:    hit = up ? pend[2] : pend[0];
            2'd3:    hit = up ? 1'b0 : (pend[0] | pend[1]);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Floor number to display code.
    function automatic logic [3:0] floor_to_code(input logic [1:0] floor);
        logic [3:0] code;
        code = FLOOR_1;
        case (floor)
            2'd2:    code = FLOOR_2;
            2'd3:    code = FLOOR_3;
            default: code = FLOOR_1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Car-controller signal bundle. There is no valid/ready handshake here: req is a
// level input sampled on every clock edge, and every output is a registered
// level that may change only on a clock edge (or on asynchronous reset).
// state_dbg exposes the controller state for checkers.
interface elevator_car_ctrl_if;
    logic [2:0] req;
    logic [2:0] pending;
    logic [3:0] floor_code;
    logic [3:0] dir_code;
    logic       door_open;
    logic       moving;
    logic [1:0] state_dbg;

    modport master (output req,
                    input  pending, floor_code, dir_code, door_open, moving, state_dbg);
    modport slave  (input  req,
                    output pending, floor_code, dir_code, door_open, moving, state_dbg);
endinterface

// File: rtl/elev_timer.sv
// Loadable down-counter shared by travel and door timing. Holds at zero.
module elev_timer #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/elevator_car_ctrl.sv
// Three-floor elevator car controller: latches calls, schedules timed moves and
// holds the door. All outputs are decoded from next-state and registered.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 100000000,
    parameter int DOOR_CYCLES   = 200000000,
    parameter int CNT_W         = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    elevator_car_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_floor;
    logic             r_last_up;
    logic [2:0]       r_pending;
    logic [3:0]       r_floor_code;
    logic [3:0]       r_dir_code;
    logic             r_door_open;
    logic             r_moving;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_floor_nx;
    logic             w_last_up_nx;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;
    logic [1:0]       w_step_up;
    logic [1:0]       w_step_dn;
    logic [2:0]       w_clr;
    logic [2:0]       w_pending_nx;
    logic [3:0]       w_dir_nx;

    elev_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Neighbouring floors, clamped to 1..3 so a corrupted FSM cannot leave the shaft.
    assign w_step_up = (r_floor >= 2'd3) ? 2'd3 : r_floor + 2'd1;
    assign w_step_dn = (r_floor <= 2'd1) ? 2'd1 : r_floor - 2'd1;

    // Next-state, floor, direction memory and timer load decisions.
    always_comb begin
        w_state_nx   = r_state;
        w_floor_nx   = r_floor;
        w_last_up_nx = r_last_up;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending & floor_onehot(r_floor)) != 3'b000) begin
                    w_state_nx = ST_DOOR;
                    w_load     = 1'b1;
                    w_load_val = DOOR_LOAD;
                end else if (calls_dir(r_floor, r_pending, r_last_up)) begin
                    w_state_nx = r_last_up ? ST_MOVE_UP : ST_MOVE_DOWN;
                    w_load     = 1'b1;
                    w_load_val = TRAVEL_LOAD;
                end else if (calls_dir(r_floor, r_pending, !r_last_up)) begin
                    w_state_nx   = r_last_up ? ST_MOVE_DOWN : ST_MOVE_UP;
                    w_last_up_nx = !r_last_up;
                    w_load       = 1'b1;
                    w_load_val   = TRAVEL_LOAD;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (w_zero) begin
                    w_floor_nx = (r_state == ST_MOVE_UP) ? w_step_up : w_step_dn;
                    if ((r_pending & floor_onehot(w_floor_nx)) != 3'b000) begin
                        w_state_nx = ST_DOOR;
                        w_load     = 1'b1;
                        w_load_val = DOOR_LOAD;
                    end else if (calls_dir(w_floor_nx, r_pending, r_state == ST_MOVE_UP)) begin
                        w_load     = 1'b1;
                        w_load_val = TRAVEL_LOAD;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                // A press at this floor re-opens the door instead of queueing a call.
                if ((bus.req & floor_onehot(r_floor)) != 3'b000) begin
                    w_load     = 1'b1;
                    w_load_val = DOOR_LOAD;
                end else if (w_zero) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_floor_nx == 2'd0) begin
            w_floor_nx = 2'd1;
        end
    end

    // Call latching; the current floor's call is cleared while the door is (or is about to be) open.
    always_comb begin
        w_clr = 3'b000;
        if (w_state_nx == ST_DOOR) begin
            w_clr = floor_onehot(w_floor_nx);
        end
        w_pending_nx = (r_pending | bus.req) & ~w_clr;
        case (w_state_nx)
            ST_MOVE_UP:   w_dir_nx = DIR_UP;
            ST_MOVE_DOWN: w_dir_nx = DIR_DOWN;
            default:      w_dir_nx = DIR_IDLE;
        endcase
    end

    // State and registered outputs, all updated from next-state on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_floor      <= 2'd1;
            r_last_up    <= 1'b1;
            r_pending    <= 3'b000;
            r_floor_code <= FLOOR_1;
            r_dir_code   <= DIR_IDLE;
            r_door_open  <= 1'b0;
            r_moving     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_floor      <= w_floor_nx;
            r_last_up    <= w_last_up_nx;
            r_pending    <= w_pending_nx;
            r_floor_code <= floor_to_code(w_floor_nx);
            r_dir_code   <= w_dir_nx;
            r_door_open  <= (w_state_nx == ST_DOOR);
            r_moving     <= (w_state_nx == ST_MOVE_UP) || (w_state_nx == ST_MOVE_DOWN);
        end
    end

    assign bus.pending    = r_pending;
    assign bus.floor_code = r_floor_code;
    assign bus.dir_code   = r_dir_code;
    assign bus.door_open  = r_door_open;
    assign bus.moving     = r_moving;
    assign bus.state_dbg  = r_state;
endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Controller FSM for a 3-floor elevator car. Latches floor-call buttons, schedules travel with a timed floor-to-floor move, and holds the door open for a fixed time.
- Directly feeds two instances of binary_to_segment: floor_code drives the floor digit, dir_code drives the direction digit.
- Both codes use the converter's encoding: 1/2/3 = floor, 4 = up, 8 = down, 12 = neutral.

Parameters:
- TRAVEL_CYCLES, 100000000: clock cycles per one-floor move (1 s at 100 MHz).
- DOOR_CYCLES, 200000000: clock cycles the door stays open.
- CNT_W, 28: width of the shared down-counter; must hold max(TRAVEL_CYCLES, DOOR_CYCLES).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  3  floor-call buttons, level, already debounced; bit0 = floor 1.
- pending  out  3  latched outstanding calls, registered.
- floor_code  out  4  current floor as 4'd1/4'd2/4'd3, registered.
- dir_code  out  4  4'd4 up, 4'd8 down, 4'd12 neutral, registered.
- door_open  out  1  high in DOOR state.
- moving  out  1  high in MOVE_UP or MOVE_DOWN.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, floor = 1, last_dir = UP, counter = 0.
  - pending = 0, floor_code = 1, dir_code = 12, door_open = 0, moving = 0.
- Call latching: pending_next = (pending | req) & ~clr.
  - clr is the one-hot of the current floor while state is DOOR or about to enter DOOR.
  - A req edge at cycle n is visible on pending after that edge.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. All outputs are registered and decoded from next-state, so they change on the same edge as the state.
- IDLE (evaluates registered pending):
  - pending[floor] set -> DOOR; load counter with DOOR_CYCLES-1.
  - Otherwise, a call exists in last_dir -> move that way.
  - Otherwise, a call exists in the opposite direction -> move that way and update last_dir.
  - Otherwise stay in IDLE.
  - Entering a move loads counter with TRAVEL_CYCLES-1.
- MOVE_x:
  - Counter decrements each cycle.
  - At counter == 0: floor += 1 (up) or -= 1 (down). Then:
    - pending[new floor] set -> DOOR.
    - Otherwise, a call exists further in the same direction -> reload counter and stay in MOVE_x.
    - Otherwise -> IDLE.
  - Calls for floors passed mid-move are not serviced until a later trip.
- Floor bounds:
  - MOVE_UP is never entered at floor 3; MOVE_DOWN is never entered at floor 1.
  - The floor register saturates at 1..3 even if the FSM is corrupted. Verification asserts this.
- DOOR:
  - Counter decrements each cycle; at 0 -> IDLE.
  - req[floor] asserted during DOOR reloads the counter to DOOR_CYCLES-1 (door re-open) and never sets pending.
- dir_code: 4 in MOVE_UP, 8 in MOVE_DOWN, 12 in IDLE and DOOR. floor_code always equals floor.
- Simultaneous events:
  - A req for another floor arriving in the same cycle as a counter expiry is latched normally and is considered from the next cycle on.
  - Multiple req bits in one cycle are all latched.
- Reset mid-move or mid-door: immediate return to the reset values; calls are lost.
- Any state encoding other than the four states recovers to IDLE.
- Latency:
  - Call at the current floor while IDLE: door_open is high 2 edges after req is sampled.
  - Call one floor away: floor_code changes TRAVEL_CYCLES+1 edges after pending is set.

Decomposition:
- Shared package elevator_pkg holds:
  - FLOOR_1/2/3 = 4'd1/2/3.
  - DIR_UP = 4'd4, DIR_DOWN = 4'd8, DIR_IDLE = 4'd12.
  - The state encoding localparams.
- These codes are the contract with binary_to_segment and must not be duplicated.
- One sub-module: elev_timer, a loadable CNT_W down-counter with load, load_val, and a zero flag. It is shared by travel and door timing.

Test Plan (TRAVEL_CYCLES = 4, DOOR_CYCLES = 6):
1. Reset then idle 20 cycles -> floor_code = 1, dir_code = 12, door_open = 0, pending = 0 throughout.
2. req = 3'b100 for 1 cycle at floor 1:
   - pending = 100; dir_code = 4.
   - floor_code becomes 2, then 3, at 4-cycle intervals.
   - door_open high for 6 cycles, pending -> 000, dir_code back to 12.
3. At floor 1, req = 3'b001 -> door_open 2 edges later, held 6 cycles; a re-press on cycle 4 of the door extends door_open to 10 cycles total.
4. Car moving up from floor 1, req = 3'b010 pulsed in the move's first cycle -> car stops at floor 2 (door_open); a pre-existing floor-3 call is serviced next with dir_code = 4.
5. At floor 2 with last_dir = UP, req = 3'b101 simultaneously -> floor 3 is serviced first, then floor 1; dir_code sequence 4, 12, 8, 12.
6. rst_n asserted asynchronously mid-MOVE_DOWN (between edges) -> outputs return to reset values before the next clk edge; no further movement until a new req.
